// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 operand stage: widths and the ALU op encoding.
package z16_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int NREG   = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_OR  = 4'd4,
    OP_AND = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } alu_op_e;

  // Highest legal ctrl code; anything above it is flagged illegal.
  localparam logic [3:0] OP_LAST = 4'd8;
endpackage

// File: rtl/z16_regfile.sv
// 16x16 register file: one write port, two combinational read ports with write bypass.
// Z16_REG0_ZERO_EN defined: R0 reads as zero and writes to it are dropped everywhere.
module z16_regfile
  import z16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [REG_AW-1:0] i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [REG_AW-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  output logic              o_wb_commit
);
  logic [DATA_W-1:0] r_mem [NREG];
  logic              w_commit;

`ifdef Z16_REG0_ZERO_EN
  assign w_commit = i_wb_en && (i_wb_addr != '0);
`else
  assign w_commit = i_wb_en;
`endif
  assign o_wb_commit = w_commit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[i_wb_addr] <= i_wb_data;
    end
  end

  // Bypass makes a write visible to readers in the same cycle it commits.
  always_comb begin
    o_ra_data = r_mem[i_ra_addr];
    o_rb_data = r_mem[i_rb_addr];
    if (w_commit && (i_wb_addr == i_ra_addr)) o_ra_data = i_wb_data;
    if (w_commit && (i_wb_addr == i_rb_addr)) o_rb_data = i_wb_data;
`ifdef Z16_REG0_ZERO_EN
    if (i_ra_addr == '0) o_ra_data = '0;
    if (i_rb_addr == '0) o_rb_data = '0;
`endif
  end
endmodule

// File: rtl/z16_operand_stage.sv
// Operand fetch ahead of the Z16 ALU: register file read, output register, writeback refresh.
// Optional build macro Z16_REG0_ZERO_EN (handled inside z16_regfile) hardwires R0 to zero.
module z16_operand_stage
  import z16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_ctrl,
  input  logic [REG_AW-1:0] i_rs_a,
  input  logic [REG_AW-1:0] i_rs_b,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_imm_en,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b,
  output logic [3:0]        o_ctrl,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_illegal,
  output logic              o_div_zero
);
  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // valid never drops and the payload never changes (except refresh) until it does.
  logic              r_valid;
  logic [DATA_W-1:0] r_a, r_b;
  logic [3:0]        r_ctrl;
  logic [REG_AW-1:0] r_rd, r_rs_a, r_rs_b;
  logic              r_imm_en;

  logic [DATA_W-1:0] w_rd_a, w_rd_b;
  logic              w_wb_commit;
  logic              w_accept;
  logic              w_stall;

  z16_regfile u_regfile (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wb_en     (i_wb_en),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_ra_addr   (i_rs_a),
    .o_ra_data   (w_rd_a),
    .i_rb_addr   (i_rs_b),
    .o_rb_data   (w_rd_b),
    .o_wb_commit (w_wb_commit)
  );

  assign o_ready  = !r_valid || i_ready;
  assign w_accept = i_valid && o_ready;
  assign w_stall  = r_valid && !i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= '0;
      r_rd     <= '0;
      r_rs_a   <= '0;
      r_rs_b   <= '0;
      r_imm_en <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_a      <= i_imm_en ? i_imm : w_rd_a;
      r_b      <= w_rd_b;
      r_ctrl   <= i_ctrl;
      r_rd     <= i_rd;
      r_rs_a   <= i_rs_a;
      r_rs_b   <= i_rs_b;
      r_imm_en <= i_imm_en;
    end else if (w_stall) begin
      // Held operands track writebacks so they are current when finally taken.
      if (w_wb_commit && (i_wb_addr == r_rs_b)) r_b <= i_wb_data;
      if (w_wb_commit && !r_imm_en && (i_wb_addr == r_rs_a)) r_a <= i_wb_data;
    end else if (r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data_a   = r_a;
  assign o_data_b   = r_b;
  assign o_ctrl     = r_ctrl;
  assign o_rd       = r_rd;
  assign o_illegal  = (r_ctrl > OP_LAST);
  assign o_div_zero = (r_ctrl == OP_DIV) && (r_a == '0);
endmodule
